// File: rtl/led_matrix_scan_ctrl_if.sv
// Bus bundle between the pattern/mode logic and the LED matrix row-scan controller.
//   enable      scan enable
//   wr_en       write one row of the back buffer
//   wr_row      row address for the write
//   wr_data     row pixels, column c at [3c+2:3c] as {R,G,B}
//   swap_req    level swap request, held until swap_ack
//   swap_ack    one-cycle pulse, buffers have swapped
//   brightness  PWM duty in sixteenths, 0 is dark
//   row         one-hot row select
//   col_rgb     column drive for the current row
//   frame_start one-cycle pulse in the first cycle of row 0 blanking
// master: pattern logic side; slave: scan controller side.
interface led_matrix_scan_ctrl_if;
  logic        enable;
  logic        wr_en;
  logic [2:0]  wr_row;
  logic [23:0] wr_data;
  logic        swap_req;
  logic        swap_ack;
  logic [3:0]  brightness;
  logic [7:0]  row;
  logic [23:0] col_rgb;
  logic        frame_start;

  modport master (
    output enable, wr_en, wr_row, wr_data, swap_req, brightness,
    input  swap_ack, row, col_rgb, frame_start
  );

  modport slave (
    input  enable, wr_en, wr_row, wr_data, swap_req, brightness,
    output swap_ack, row, col_rgb, frame_start
  );
endinterface

// File: rtl/led_matrix_scan_ctrl.sv
// Row-scan scheduler for an 8x8 RGB LED matrix with a double-buffered frame.
// Each row slot is ROW_DWELL cycles: BLANK_CYCLES dark cycles against ghosting, then an active
// window in which the row is driven and the columns are gated by a 4-bit PWM against brightness.
// The back buffer is written row by row; a requested swap takes effect at the frame boundary
// (end of row 7 active), or immediately while idle.
// Ports:
//   clk      clock
//   rst      asynchronous reset, active-high
//   scan_io  slave side of led_matrix_scan_ctrl_if (see that file for signal list)
// Optional build macro LED_SCAN_ACTIVE_LOW_EN: row and col_rgb are inverted at the output
// register for common-anode drivers, so dark (and reset) is all-ones.
module led_matrix_scan_ctrl #(
  parameter int unsigned ROW_DWELL    = 6250,
  parameter int unsigned BLANK_CYCLES = 50
) (
  input logic                         clk,
  input logic                         rst,
  led_matrix_scan_ctrl_if.slave       scan_io
);

  localparam logic [15:0] BlankLast  = 16'(BLANK_CYCLES - 1);
  localparam logic [15:0] ActiveLast = 16'(ROW_DWELL - BLANK_CYCLES - 1);

`ifdef LED_SCAN_ACTIVE_LOW_EN
  localparam logic [7:0]  RowInv = 8'hFF;
  localparam logic [23:0] ColInv = 24'hFFFFFF;
`else
  localparam logic [7:0]  RowInv = 8'h00;
  localparam logic [23:0] ColInv = 24'h000000;
`endif

  typedef enum logic [1:0] {StIdle, StBlank, StActive} state_e;

  state_e      state_q, state_d;
  logic [2:0]  row_idx_q, row_idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  pwm_q, pwm_d;
  logic        sel_q, sel_d;
  logic        block_q, block_d;
  logic        swap_do, swap_ok;

  logic [23:0] buf_q [2][8];

  logic [7:0]  row_q, row_d;
  logic [23:0] col_q, col_d;
  logic        ack_q;
  logic        fs_q, fs_d;

  // A swap is honoured once per request level; block_q holds until swap_req drops.
  assign swap_ok = scan_io.swap_req && !block_q;

  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    cnt_d     = cnt_q;
    pwm_d     = pwm_q;
    swap_do   = 1'b0;
    if (!scan_io.enable) begin
      state_d   = StIdle;
      row_idx_d = '0;
      cnt_d     = '0;
      pwm_d     = '0;
      swap_do   = (state_q == StIdle) && swap_ok;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d   = StBlank;
          row_idx_d = '0;
          cnt_d     = '0;
          pwm_d     = '0;
          swap_do   = swap_ok;
        end
        StBlank: begin
          if (cnt_q == BlankLast) begin
            state_d = StActive;
            cnt_d   = '0;
            pwm_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StActive: begin
          pwm_d = pwm_q + 4'd1;
          if (cnt_q == ActiveLast) begin
            state_d   = StBlank;
            cnt_d     = '0;
            row_idx_d = row_idx_q + 3'd1;
            swap_do   = (row_idx_q == 3'd7) && swap_ok;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          state_d   = StIdle;
          row_idx_d = '0;
          cnt_d     = '0;
          pwm_d     = '0;
        end
      endcase
    end
  end

  always_comb begin
    sel_d   = sel_q ^ swap_do;
    block_d = swap_do ? 1'b1 : (scan_io.swap_req ? block_q : 1'b0);
  end

  // Outputs are built from next-state so the registered outputs track the state registers.
  always_comb begin
    row_d = '0;
    col_d = '0;
    fs_d  = (state_d == StBlank) && (row_idx_d == 3'd0) && (cnt_d == 16'd0);
    if (state_d == StActive) begin
      row_d = 8'b1 << row_idx_d;
      if (pwm_d < scan_io.brightness) begin
        col_d = buf_q[sel_d][row_idx_d];
      end
    end
    row_d = row_d ^ RowInv;
    col_d = col_d ^ ColInv;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      row_idx_q <= '0;
      cnt_q     <= '0;
      pwm_q     <= '0;
      sel_q     <= 1'b0;
      block_q   <= 1'b0;
      row_q     <= RowInv;
      col_q     <= ColInv;
      ack_q     <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      cnt_q     <= cnt_d;
      pwm_q     <= pwm_d;
      sel_q     <= sel_d;
      block_q   <= block_d;
      row_q     <= row_d;
      col_q     <= col_d;
      ack_q     <= swap_do;
      fs_q      <= fs_d;
    end
  end

  // Writes always target the pre-toggle back buffer, even in a swap cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 8; r++) begin
          buf_q[b][r] <= '0;
        end
      end
    end else if (scan_io.wr_en) begin
      buf_q[~sel_q][scan_io.wr_row] <= scan_io.wr_data;
    end
  end

  assign scan_io.row         = row_q;
  assign scan_io.col_rgb     = col_q;
  assign scan_io.swap_ack    = ack_q;
  assign scan_io.frame_start = fs_q;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Bench for led_matrix_scan_ctrl with ROW_DWELL=20, BLANK_CYCLES=4 (16-cycle active windows,
// 160-cycle frames). Stimulus pushes expected row windows and frame_start/swap_ack events;
// a monitor reconstructs windows from the outputs and compares them against the queues.
module tb_led_matrix_scan_ctrl;

`ifdef LED_SCAN_ACTIVE_LOW_EN
  localparam logic [7:0]  RMASK = 8'hFF;
  localparam logic [23:0] CMASK = 24'hFFFFFF;
`else
  localparam logic [7:0]  RMASK = 8'h00;
  localparam logic [23:0] CMASK = 24'h000000;
`endif

  typedef struct {
    logic [7:0]  row;
    int          len;
    int          lit;
    logic [23:0] val;
  } win_t;

  typedef struct {
    bit fs;
    bit ack;
    int gap;
  } evt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  win_t wq[$];
  evt_t eq[$];

  led_matrix_scan_ctrl_if bus ();

  led_matrix_scan_ctrl #(
    .ROW_DWELL   (20),
    .BLANK_CYCLES(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .scan_io(bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Lit count follows the PWM: cycle k of the window is lit when k < brightness.
  task automatic push_win(input int idx, input int len, input int b, input logic [23:0] v);
    win_t w;
    w.row = 8'b1 << idx;
    w.len = len;
    w.lit = (v == 24'h0) ? 0 : ((len < b) ? len : b);
    w.val = (w.lit == 0) ? 24'h0 : v;
    wq.push_back(w);
  endtask

  task automatic push_frame(input int b, input logic [23:0] d3, input logic [23:0] d5,
                            input int nrows);
    for (int i = 0; i < nrows; i++) begin
      push_win(i, 16, b, (i == 3) ? d3 : ((i == 5) ? d5 : 24'h0));
    end
  endtask

  task automatic push_evt(input bit fs, input bit ack, input int gap);
    evt_t e;
    e.fs  = fs;
    e.ack = ack;
    e.gap = gap;
    eq.push_back(e);
  endtask

  task automatic wait_fs(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_start && n < 400);
    if (!bus.frame_start) check(tag, 0, 1);
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.swap_ack && n < 50);
    if (!bus.swap_ack) check(tag, 0, 1);
  endtask

  task automatic wait_row(input logic [7:0] target, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((bus.row ^ RMASK) != target) && n < 400);
    if ((bus.row ^ RMASK) != target) check(tag, 0, 1);
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_row"}, 32'(bus.row ^ RMASK), 0);
    check({tag, "_col"}, 32'(bus.col_rgb ^ CMASK), 0);
  endtask

  // Monitor: rebuild row windows and events from the outputs, compare against the queues.
  initial begin
    logic [7:0]  r;
    logic [23:0] c;
    logic [7:0]  w_row = '0;
    bit          in_win = 0;
    int          w_len = 0;
    int          w_lit = 0;
    logic [23:0] w_val = '0;
    int          last_fs = 0;
    win_t        w;
    evt_t        e;
    forever begin
      @(negedge clk);
      r = bus.row ^ RMASK;
      c = bus.col_rgb ^ CMASK;
      if (in_win && (r != w_row)) begin
        in_win = 0;
        if (wq.size() == 0) begin
          check("win_unexpected", 32'(w_row), 0);
        end else begin
          w = wq.pop_front();
          check("win_row", 32'(w_row), 32'(w.row));
          check("win_len", w_len, w.len);
          check("win_lit", w_lit, w.lit);
          check("win_val", 32'(w_val), 32'(w.val));
        end
      end
      if (r != 0) begin
        if (!in_win) begin
          in_win = 1;
          w_row  = r;
          w_len  = 0;
          w_lit  = 0;
          w_val  = '0;
        end
        w_len++;
        if (c != 0) begin
          w_lit++;
          w_val = c;
        end
      end else if (c != 0) begin
        check("dark_col", 32'(c), 0);
      end
      if (bus.frame_start || bus.swap_ack) begin
        if (eq.size() == 0) begin
          check("evt_unexpected", {30'd0, bus.frame_start, bus.swap_ack}, 0);
        end else begin
          e = eq.pop_front();
          check("evt_fs", 32'(bus.frame_start), 32'(e.fs));
          check("evt_ack", 32'(bus.swap_ack), 32'(e.ack));
          if (bus.frame_start && e.gap != 0) check("frame_period", cyc - last_fs, e.gap);
        end
        if (bus.frame_start) last_fs = cyc;
      end
    end
  end

  initial begin
    bus.enable     = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_row     = '0;
    bus.wr_data    = '0;
    bus.swap_req   = 1'b0;
    bus.brightness = 4'd15;
    repeat (3) @(negedge clk);
    check_dark("reset");
    check("reset_ack", 32'(bus.swap_ack), 0);
    check("reset_fs", 32'(bus.frame_start), 0);
    rst = 1'b0;
    @(negedge clk);
    check_dark("idle");

    // Frames 1..4 full, frame 5 cut in row 5 after 6 active cycles.
    push_evt(1, 0, 0);   push_frame(15, 24'h0, 24'h0, 8);
    push_evt(1, 1, 160); push_frame(15, 24'hFFFFFF, 24'h123456, 8);
    push_evt(1, 0, 160); push_frame(4, 24'hFFFFFF, 24'h123456, 8);
    push_evt(1, 0, 160); push_frame(0, 24'hFFFFFF, 24'h123456, 8);
    push_evt(1, 0, 160); push_frame(15, 24'hFFFFFF, 24'h123456, 5);
    push_win(5, 6, 15, 24'h123456);

    bus.enable = 1'b1;
    @(negedge clk);
    check("first_fs", 32'(bus.frame_start), 1);
    repeat (3) @(negedge clk);
    check("blank_row", 32'(bus.row ^ RMASK), 0);
    @(negedge clk);
    check("first_lit_row", 32'(bus.row ^ RMASK), 32'h01);

    // Back-to-back writes to the back buffer; front must stay dark this frame.
    bus.wr_en   = 1'b1;
    bus.wr_row  = 3'd3;
    bus.wr_data = 24'hFFFFFF;
    @(negedge clk);
    bus.wr_row  = 3'd5;
    bus.wr_data = 24'h123456;
    @(negedge clk);
    bus.wr_en   = 1'b0;

    wait_row(8'h10, "to_row4");
    bus.swap_req = 1'b1;
    wait_fs("fs_frame2");
    // Request held across the ack: must not cause a second swap.
    wait_fs("fs_frame3");
    bus.swap_req   = 1'b0;
    bus.brightness = 4'd4;
    wait_fs("fs_frame4");
    bus.brightness = 4'd0;
    wait_fs("fs_frame5");
    bus.brightness = 4'd15;
    wait_row(8'h20, "to_row5");
    repeat (5) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    check_dark("disable");
    repeat (5) @(negedge clk);

    // Restart, then reset mid row 2 with a swap pending.
    push_evt(1, 0, 0);
    push_win(0, 16, 15, 24'h0);
    push_win(1, 16, 15, 24'h0);
    push_win(2, 4, 15, 24'h0);
    bus.enable = 1'b1;
    wait_fs("fs_restart");
    wait_row(8'h04, "to_row2");
    bus.swap_req = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_dark("async_rst");
    check("async_rst_ack", 32'(bus.swap_ack), 0);
    check("async_rst_fs", 32'(bus.frame_start), 0);
    bus.swap_req = 1'b0;
    bus.enable   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Swap while idle exposes the other buffer; both must be cleared.
    push_evt(0, 1, 0);
    bus.swap_req = 1'b1;
    wait_ack("idle_ack");
    bus.swap_req = 1'b0;
    push_evt(1, 0, 0);   push_frame(15, 24'h0, 24'h0, 8);
    push_evt(1, 0, 160);
    @(negedge clk);
    bus.enable = 1'b1;
    wait_fs("fs_frame7");
    wait_fs("fs_frame8");
    bus.enable = 1'b0;
    repeat (5) @(negedge clk);
    check("win_left", wq.size(), 0);
    check("evt_left", eq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_matrix_scan_ctrl.md
# led_matrix_scan_ctrl

Row-scan scheduler for the 8x8 RGB LED matrix. It holds a double-buffered frame: 2 buffers x 8 rows x 8 columns x 3-bit RGB. It drives one row at a time with a programmable dwell, a blanking gap against ghosting, and global PWM brightness. Mode/pattern logic writes the back buffer and requests a tear-free swap, which takes effect at a frame boundary.

## Interface
- ROW_DWELL, 6250: clock cycles per row slot (50 MHz / 6250 / 8 rows = 1 kHz frame); 16-bit; must exceed BLANK_CYCLES.
- BLANK_CYCLES, 50: leading cycles of each slot with all outputs dark; at least 1.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- enable  in  1  scan enable.
- wr_en  in  1  write one row of the back buffer.
- wr_row  in  3  row address for the write.
- wr_data  in  24  row pixels; column c occupies [3c+2:3c] as {R,G,B}.
- swap_req  in  1  level; held high until swap_ack is seen.
- swap_ack  out  1  one-cycle pulse; buffers have swapped.
- brightness  in  4  duty in sixteenths; 0 means dark.
- row  out  8  one-hot row select, active-high.
- col_rgb  out  24  column drive for the current row, same packing as wr_data.
- frame_start  out  1  one-cycle pulse in the first cycle of row 0 blanking.

## Operation
- States:
  - IDLE: outputs dark; row counter 0.
  - BLANK: row=0, col_rgb=0 for BLANK_CYCLES cycles.
  - ACTIVE: ROW_DWELL-BLANK_CYCLES cycles; row=one-hot(row_idx).
- Transitions:
  - IDLE to BLANK of row 0 on enable=1.
  - BLANK to ACTIVE when the blank count expires.
  - ACTIVE to BLANK of row_idx+1 when the slot count expires.
  - row_idx wraps 7 to 0; frame_start pulses on each entry to row 0 BLANK.
  - Any state to IDLE on enable=0, registered at the next edge. Counters and row_idx reset; the frame is not completed.
- PWM:
  - A 4-bit pwm_cnt clears at ACTIVE entry and increments each ACTIVE cycle, wrapping.
  - col_rgb = front[row_idx] when pwm_cnt < brightness, else 0. The row output stays asserted for the whole ACTIVE window.
  - Maximum duty is 15/16. brightness is sampled every cycle.
- Writes: wr_en writes wr_data into back[wr_row] at the edge. Writes never touch the front buffer. Back-to-back writes are allowed every cycle.
- Swap:
  - With swap_req=1, the front/back select toggles at the last cycle of row 7 ACTIVE.
  - In IDLE the toggle happens on the first edge where swap_req is seen.
  - swap_ack pulses in the cycle after the toggle.
  - A new swap needs swap_req low for at least one cycle after swap_ack. A level held through ack does not cause a second swap.
- Simultaneous write and swap: the write lands in the pre-toggle back buffer, which becomes front. Writers must not write in the swap cycle if they need the old back contents.
- Reset: both buffers are cleared to 0. Select is 0, state IDLE, row_idx 0, pwm_cnt 0. row=0, col_rgb=0, swap_ack=0, frame_start=0 (polarity per Configuration). A pending swap is dropped.

## Timing
- All outputs are registered and update one cycle after the state/counter change that causes them.
- First lit output: enable rises at cycle 0, and BLANK row 0 with frame_start is visible at cycle 1. row[0] is high from cycle 1+BLANK_CYCLES.
- Frame period: exactly 8*ROW_DWELL cycles with no dead cycles between slots.
- Swap latency: at most one frame plus 1 cycle from swap_req to the new data appearing at row 0. swap_ack coincides with the frame_start of the first new frame.
- Write-to-display: written data appears only after a subsequent swap.

## Configuration
- LED_SCAN_ACTIVE_LOW_EN:
  - Defined: row and col_rgb are bitwise inverted at the output register for common-anode drivers. Dark is all-ones, including the reset values row=8'hFF and col_rgb=24'hFFFFFF.
  - Undefined: active-high, and dark is all-zeros.
- swap_ack and frame_start are unaffected by the macro.

## Test plan
- ROW_DWELL=20, BLANK_CYCLES=4, brightness=15, front all-zero, enable=1 -> row cycles 01,02,…,80 with 16 high cycles per slot; col_rgb=0; frame_start every 160 cycles.
- Write back[3]=24'hFFFFFF, assert swap_req mid-frame -> swap_ack pulses with the next frame_start. During the row 3 active window, col_rgb=FFFFFF for 15 of 16 cycles; all other rows are 0.
- brightness=4 with a full frame -> per active window col_rgb is lit exactly 4 of 16 cycles. brightness=0 -> col_rgb stays 0 and row still scans.
- Deassert enable mid row 5 -> the next cycle shows row=0 and col_rgb=0. Re-enable -> restarts at row 0 with frame_start.
- Assert rst mid-ACTIVE, also with a swap pending -> outputs go to reset values immediately. No swap_ack follows, and both buffers read 0 after release.
- With LED_SCAN_ACTIVE_LOW_EN defined, repeat the first scenario -> row active bit low, idle row=FF, col_rgb=FFFFFF.
